// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and fetch geometry.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StHold   = 2'b10
  } fetch_state_e;

  localparam int unsigned InstrWidth = 32;
  localparam logic [31:0] PcIncr     = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer for {pc, instruction} entries; synchronous flush beats push and pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

  // A pop frees a slot in the same edge, so a full FIFO can still accept a push.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: sequential ROM reads into a prefetch FIFO with redirect support.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] address,
  output logic        chip_select,
  output logic        output_enable,
  input  logic [63:0] data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_word,
  output logic [31:0] instr_pc
);

  localparam int unsigned    CntW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned    EntryW    = 2 * InstrWidth;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [2:0]     WaitLast  = 3'(WAIT_CYCLES);
  localparam logic [31:0]    ResetPcAl = {RESET_PC[31:2], 2'b00};

  fetch_state_e    state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [2:0]      wait_q, wait_d;
  logic            started_q;
  logic [31:0]     addr_hold_q;

  logic            push, pop, space;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [EntryW-1:0] fifo_head;

  logic unused_bits;
  assign unused_bits = ^{data[63:32], redirect_pc[1:0], fifo_empty};

  assign instr_valid = !fifo_empty;
  assign pop         = instr_valid && instr_ready;
  // A pop in this cycle frees a slot at the coming edge.
  assign space       = !fifo_full || pop;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wait_d     = wait_q;
    push       = 1'b0;

    case (state_q)
      StIdle: begin
        // started_q holds off the first access by one edge after reset release.
        if (started_q) state_d = space ? StAccess : StHold;
      end
      StAccess: begin
        if (wait_q == WaitLast) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + PcIncr;
          wait_d     = '0;
          state_d    = (pop || (fifo_count + CntW'(1) < DepthCnt)) ? StAccess : StHold;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      StHold: begin
        if (space) state_d = StAccess;
      end
      default: state_d = StIdle;
    endcase

    if (redirect) begin
      state_d    = StIdle;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wait_d     = '0;
      push       = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      fetch_pc_q  <= ResetPcAl;
      wait_q      <= '0;
      started_q   <= 1'b0;
      addr_hold_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wait_q     <= wait_d;
      started_q  <= 1'b1;
      if (state_q == StAccess) addr_hold_q <= fetch_pc_q;
    end
  end

  assign chip_select   = (state_q == StAccess);
  assign output_enable = (state_q == StAccess);
  assign address       = (state_q == StAccess) ? fetch_pc_q : addr_hold_q;

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EntryW)
  ) u_fetch_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .push_data({fetch_pc_q, data[InstrWidth-1:0]}),
    .pop      (pop),
    .flush    (redirect),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign instr_pc   = fifo_head[EntryW-1:InstrWidth];
  assign instr_word = fifo_head[InstrWidth-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-cycle vector table plus a reset-abort sequence.
module tb_instruction_fetch;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // DUT A: default parameters
  logic        reset_n_a, redirect_a, instr_ready_a, cs_a, oe_a, valid_a;
  logic [31:0] redirect_pc_a, address_a, word_a, pc_a;
  logic [63:0] data_a;

  // DUT B: three wait cycles, misaligned reset pc
  logic        reset_n_b, redirect_b, instr_ready_b, cs_b, oe_b, valid_b;
  logic [31:0] redirect_pc_b, address_b, word_b, pc_b;
  logic [63:0] data_b;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h0000_0200) ? 32'h0000_0000 : (a ^ 32'hC0DE_0000);
  endfunction

  assign data_a = {32'hFFFF_FFFF, rom(address_a)};
  assign data_b = {32'hFFFF_FFFF, rom(address_b)};

  instruction_fetch u_dut_a (
    .clock        (clock),
    .reset_n      (reset_n_a),
    .address      (address_a),
    .chip_select  (cs_a),
    .output_enable(oe_a),
    .data         (data_a),
    .redirect     (redirect_a),
    .redirect_pc  (redirect_pc_a),
    .instr_valid  (valid_a),
    .instr_ready  (instr_ready_a),
    .instr_word   (word_a),
    .instr_pc     (pc_a)
  );

  instruction_fetch #(
    .RESET_PC   (32'h0000_1002),
    .WAIT_CYCLES(3),
    .FIFO_DEPTH (2)
  ) u_dut_b (
    .clock        (clock),
    .reset_n      (reset_n_b),
    .address      (address_b),
    .chip_select  (cs_b),
    .output_enable(oe_b),
    .data         (data_b),
    .redirect     (redirect_b),
    .redirect_pc  (redirect_pc_b),
    .instr_valid  (valid_b),
    .instr_ready  (instr_ready_b),
    .instr_word   (word_b),
    .instr_pc     (pc_b)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Row: checked at a falling edge, then its inputs are driven for the next rising edge.
  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        cs;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } row_t;

  function automatic row_t mk(input logic rst_n, input logic ready, input logic redir,
                              input logic [31:0] rpc, input logic cs, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc);
    row_t r;
    r.rst_n = rst_n; r.ready = ready; r.redir = redir; r.rpc = rpc;
    r.cs = cs; r.addr = addr; r.valid = valid; r.pc = pc;
    return r;
  endfunction

  row_t rows[$];

  initial begin
    int n;
    reset_n_a = 1'b1; redirect_a = 1'b0; redirect_pc_a = '0; instr_ready_a = 1'b1;
    reset_n_b = 1'b1; redirect_b = 1'b0; redirect_pc_b = '0; instr_ready_b = 1'b0;
    #1;
    reset_n_a = 1'b0;
    reset_n_b = 1'b0;

    //                    drive: rst ready redir rpc            expect: cs addr valid pc
    rows.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0));  // in reset
    rows.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0));  // release
    rows.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0));  // idle
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h4,         1, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h4,         0, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h8,         1, 32'h4));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h8,         0, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'hC,         1, 32'h8));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'hC,         0, 32'h0));
    rows.push_back(mk(1, 1, 1, 32'hFFFF_FFFC, 1, 32'h10,        1, 32'hC));  // wrap redirect
    rows.push_back(mk(1, 1, 0, 32'h0,         0, 32'h10,        0, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFFC));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h4,         1, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h4,         0, 32'h0));
    rows.push_back(mk(1, 1, 1, 32'h103,       1, 32'h8,         1, 32'h4));  // abort fetch of 8
    rows.push_back(mk(1, 1, 0, 32'h0,         0, 32'h8,         0, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h100,       0, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h100,       0, 32'h0));
    rows.push_back(mk(1, 0, 0, 32'h0,         1, 32'h104,       1, 32'h100));
    rows.push_back(mk(1, 1, 1, 32'h200,       1, 32'h104,       1, 32'h100)); // redirect+pop+push
    rows.push_back(mk(1, 1, 0, 32'h0,         0, 32'h104,       0, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h200,       0, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h200,       0, 32'h0));
    rows.push_back(mk(1, 1, 0, 32'h0,         1, 32'h204,       1, 32'h200)); // zero word
    rows.push_back(mk(0, 0, 0, 32'h0,         1, 32'h204,       0, 32'h0));  // reset again
    rows.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0));
    rows.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0));
    rows.push_back(mk(1, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0));
    rows.push_back(mk(1, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0));
    rows.push_back(mk(1, 0, 0, 32'h0,         1, 32'h4,         1, 32'h0));
    rows.push_back(mk(1, 0, 0, 32'h0,         1, 32'h4,         1, 32'h0));
    rows.push_back(mk(1, 0, 0, 32'h0,         0, 32'h4,         1, 32'h0));  // hold, full
    rows.push_back(mk(1, 1, 0, 32'h0,         0, 32'h4,         1, 32'h0));
    rows.push_back(mk(1, 0, 0, 32'h0,         1, 32'h8,         1, 32'h4));
    rows.push_back(mk(1, 0, 0, 32'h0,         1, 32'h8,         1, 32'h4));
    rows.push_back(mk(1, 0, 0, 32'h0,         0, 32'h8,         1, 32'h4));

    foreach (rows[i]) begin
      @(negedge clock);
      check1($sformatf("row%0d chip_select", i), cs_a, rows[i].cs);
      check1($sformatf("row%0d output_enable", i), oe_a, rows[i].cs);
      check32($sformatf("row%0d address", i), address_a, rows[i].addr);
      check1($sformatf("row%0d instr_valid", i), valid_a, rows[i].valid);
      if (rows[i].valid) begin
        check32($sformatf("row%0d instr_pc", i), pc_a, rows[i].pc);
        check32($sformatf("row%0d instr_word", i), word_a, rom(rows[i].pc));
      end
      reset_n_a     = rows[i].rst_n;
      instr_ready_a = rows[i].ready;
      redirect_a    = rows[i].redir;
      redirect_pc_a = rows[i].rpc;
    end

    // DUT B: reset pulse in the second wait cycle of an access.
    @(negedge clock);
    check32("b reset address", address_b, 32'h0000_1002);
    reset_n_b = 1'b1;
    @(negedge clock);
    check1("b idle cs", cs_b, 1'b0);
    @(negedge clock);
    check1("b first access cs", cs_b, 1'b1);
    check32("b first access address", address_b, 32'h0000_1000);
    n = 0;
    while (!valid_b && n < 20) begin
      @(negedge clock);
      n++;
    end
    check32("b fetch latency", n, 4);
    check32("b first pc", pc_b, 32'h0000_1000);
    check32("b first word", word_b, rom(32'h0000_1000));
    @(negedge clock);
    @(negedge clock);
    check1("b mid access cs", cs_b, 1'b1);
    check32("b mid access address", address_b, 32'h0000_1004);
    #1 reset_n_b = 1'b0;
    #1;
    check1("b async cs drop", cs_b, 1'b0);
    check1("b async oe drop", oe_b, 1'b0);
    check1("b async valid drop", valid_b, 1'b0);
    #1 reset_n_b = 1'b1;
    @(negedge clock);
    check1("b restart idle cs", cs_b, 1'b0);
    @(negedge clock);
    check1("b restart cs", cs_b, 1'b1);
    check32("b restart address", address_b, 32'h0000_1000);
    check1("b restart valid", valid_b, 1'b0);
    n = 0;
    while (!valid_b && n < 20) begin
      @(negedge clock);
      n++;
    end
    check1("b restart got valid", valid_b, 1'b1);
    check32("b restart pc", pc_b, 32'h0000_1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, range 0-7, meaning extra ROM access cycles before data is sampled.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 2, power of two >=2, meaning prefetch buffer entries.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 The ports SHALL be, in order:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- address  output  32  ROM address.
- chip_select  output  1  ROM select.
- output_enable  output  1  ROM output drive enable.
- data  input  64  ROM read data; only bits [31:0] are used.
- redirect  input  1  pipeline branch/flush request.
- redirect_pc  input  32  new fetch address.
- instr_valid  output  1  instr_word/instr_pc hold a fetched instruction.
- instr_ready  input  1  consumer accepts the instruction.
- instr_word  output  32  fetched instruction.
- instr_pc  output  32  address instr_word was fetched from.

Function
REQ-006 The block SHALL be a state machine with states IDLE, ACCESS and HOLD.
REQ-007 In IDLE it SHALL enter ACCESS on the next edge when the occupancy of fetch_fifo is below FIFO_DEPTH; otherwise it SHALL enter HOLD.
REQ-008 In ACCESS:
- chip_select=1, output_enable=1, address=fetch_pc.
- The state lasts WAIT_CYCLES+1 cycles.
- On the rising edge ending the last cycle, the block SHALL push {fetch_pc, data[31:0]} to fetch_fifo and set fetch_pc += 4.
REQ-009 After a push, the block SHALL stay in ACCESS for back-to-back fetches when the FIFO has space (counting the entry just pushed); otherwise it SHALL enter HOLD.
REQ-010 In HOLD:
- chip_select=0, output_enable=0, address holds its last value.
- The block SHALL enter ACCESS on the edge after occupancy drops below FIFO_DEPTH.
REQ-011 In IDLE, chip_select=0 and output_enable=0.
REQ-012 Consumer handshake:
- instr_valid = FIFO not empty.
- instr_word/instr_pc = FIFO head.
- A pop occurs when instr_valid && instr_ready.
- While instr_valid=1 and instr_ready=0, the outputs SHALL remain stable.
REQ-013 A simultaneous push and pop on a full-minus-one or full FIFO SHALL both take effect; occupancy is unchanged and no entry is lost.
REQ-014 On a redirect:
- When redirect=1 at an edge, the block SHALL flush the FIFO (instr_valid=0 next cycle).
- It SHALL abort any in-progress access with no push.
- It SHALL load fetch_pc = {redirect_pc[31:2], 2'b00} and enter IDLE.
- Redirect SHALL take priority over push and pop in the same cycle.
REQ-015 After a redirect, chip_select SHALL be low for exactly one cycle (IDLE turnaround) before the new ACCESS.
REQ-016 fetch_pc SHALL wrap from 32'hFFFFFFFC to 32'h00000000 with no error indication.
REQ-017 A default-address ROM word (all zeros) SHALL be delivered as a normal instruction; the block performs no decoding.
REQ-018 fetch_pc advances only on a push, never on a pop.

Reset
REQ-019 While reset_n=0:
- state=IDLE, fetch_pc=RESET_PC with bits [1:0] forced to 0, address=RESET_PC.
- chip_select=0, output_enable=0, FIFO empty, instr_valid=0, wait counter=0.
REQ-020 Reset asserted mid-access SHALL immediately deassert chip_select/output_enable asynchronously, and the partial fetch SHALL be discarded.
REQ-021 The first ACCESS SHALL start on the second rising edge after reset_n deasserts.

Structure
REQ-022 A shared package SHALL hold the fetch state enumeration (IDLE/ACCESS/HOLD), the instruction width (32) and the PC increment (4).
REQ-023 The prefetch buffer SHALL be a sub-module fetch_fifo with:
- parameters DEPTH and WIDTH (64 = pc+word);
- ports push, pop, flush, full, empty, count.
REQ-024 fetch_fifo flush SHALL be synchronous and override push/pop.

Verification
REQ-025 Reset release with instr_ready=1 held, WAIT_CYCLES=1, ROM words W0..W3 at 0,4,8,C -> instr_pc 0,4,8,C in order, one new instruction every 2 cycles, chip_select continuously high.
REQ-026 instr_ready=0 from reset -> exactly 2 fetches (addresses 0,4), then chip_select=0 (HOLD); raising instr_ready pops addr 0 and fetch of 8 starts the next cycle.
REQ-027 redirect=1, redirect_pc=32'h00000103 during the ACCESS of address 8 -> no push of 8, instr_valid=0 next cycle, one cycle chip_select=0, then address=32'h00000100.
REQ-028 redirect coincident with pop and push -> FIFO empty afterwards, and the popped word is the only one observed.
REQ-029 redirect_pc=32'hFFFFFFFC with instr_ready=1 -> instr_pc sequence FFFFFFFC, 00000000, 00000004.
REQ-030 reset_n pulsed low during the second wait cycle with WAIT_CYCLES=3 -> chip_select drops asynchronously, instr_valid=0, fetch restarts at RESET_PC.
